// File: rtl/sysid_boot_checker_pkg.sv
// Shared definitions for the system-ID boot checker.
//   - FSM state encoding (3-bit)
//   - word addresses of the system-ID slave
//   - saturating 2-bit increment used by the attempt counter
package sysid_boot_checker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_ID   = 3'd1;
  localparam state_t ST_WAIT_ID = 3'd2;
  localparam state_t ST_RD_TS   = 3'd3;
  localparam state_t ST_WAIT_TS = 3'd4;
  localparam state_t ST_CHECK   = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/sysid_read_port.sv
// Single-outstanding Avalon-MM read handshake with a fixed read latency.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   go                  hold high to request a read (drives avm_read directly)
//   accept              read accepted this cycle (go and no waitrequest)
//   rd_done, rd_data    rd_data is valid to capture in the cycle rd_done=1
//   avm_*               Avalon-MM read signals towards the slave
module sysid_read_port #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  output logic        accept,
  output logic        rd_done,
  output logic [31:0] rd_data,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  // Counter preload; latency 0 never uses the counter.
  localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  logic       pend_q, pend_d;
  logic [1:0] cnt_q,  cnt_d;

  // The strobe follows go, so address/read stay stable while the slave stalls.
  assign avm_read = go;
  assign accept   = go && !avm_waitrequest;
  assign rd_data  = avm_readdata;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    rd_done = 1'b0;
    if (READ_LATENCY == 0) begin
      rd_done = accept;
    end else if (pend_q) begin
      if (cnt_q == 2'd0) begin
        rd_done = 1'b1;
        pend_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (accept) begin
      pend_d = 1'b1;
      cnt_d  = LAT_LOAD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID slave (word 0 = ID, word 1 = build timestamp), compares
// both against expected values and retries on mismatch.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   start                 request a check; honoured only in IDLE/DONE
//   avm_address/read      Avalon-MM read master towards the system-ID slave
//   avm_waitrequest/readdata
//   busy, done            sequence running / finished (done held until next start)
//   id_ok, ts_ok, pass    comparison results registered in CHECK
//   read_id, read_ts      last captured words
//   attempts              sequences run in the current check, saturating at 3
module sysid_boot_checker
  import sysid_boot_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'd1456583469,
  parameter int          READ_LATENCY = 1,
  parameter int          MAX_RETRIES  = 2,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic [1:0]  attempts
);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [1:0]  retry_q, retry_d;
  logic [1:0]  attempts_q, attempts_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, pass_q, pass_d;
  logic [31:0] read_id_q, read_id_d, read_ts_q, read_ts_d;

  logic        rd_go, rd_accept, rd_done;
  logic [31:0] rd_data;
  logic        launch, chk_pass, retry_ok;

  sysid_read_port #(.READ_LATENCY(READ_LATENCY)) u_read_port (
    .clock          (clock),
    .reset_n        (reset_n),
    .go             (rd_go),
    .accept         (rd_accept),
    .rd_done        (rd_done),
    .rd_data        (rd_data),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata)
  );

  // auto_q is a one-shot that stands in for start on the first clock after reset.
  assign launch   = ((state_q == ST_IDLE) && (auto_q || start)) ||
                    ((state_q == ST_DONE) && start);
  assign chk_pass = (read_id_q == EXPECTED_ID) && (read_ts_q == EXPECTED_TS);
  assign retry_ok = (retry_q < 2'(MAX_RETRIES));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_START;
      retry_q    <= 2'd0;
      attempts_q <= 2'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      pass_q     <= 1'b0;
      read_id_q  <= 32'd0;
      read_ts_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      retry_q    <= retry_d;
      attempts_q <= attempts_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      pass_q     <= pass_d;
      read_id_q  <= read_id_d;
      read_ts_q  <= read_ts_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (launch) state_d = ST_RD_ID;
      ST_RD_ID:   if (rd_accept) state_d = (READ_LATENCY == 0) ? ST_RD_TS : ST_WAIT_ID;
      ST_WAIT_ID: if (rd_done) state_d = ST_RD_TS;
      ST_RD_TS:   if (rd_accept) state_d = (READ_LATENCY == 0) ? ST_CHECK : ST_WAIT_TS;
      ST_WAIT_TS: if (rd_done) state_d = ST_CHECK;
      ST_CHECK:   state_d = (!chk_pass && retry_ok) ? ST_RD_ID : ST_DONE;
      ST_DONE:    if (launch) state_d = ST_RD_ID;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath updates
  always_comb begin
    auto_d      = 1'b0;
    retry_d     = retry_q;
    attempts_d  = attempts_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    pass_d      = pass_q;
    read_id_d   = read_id_q;
    read_ts_d   = read_ts_q;

    rd_go       = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    avm_address = ((state_q == ST_RD_TS) || (state_q == ST_WAIT_TS)) ? SYSID_ADDR_TS
                                                                     : SYSID_ADDR_ID;
    busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done        = (state_q == ST_DONE);

    // A new check clears status; captured words hold until overwritten.
    if (launch) begin
      retry_d    = 2'd0;
      attempts_d = 2'd0;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      pass_d     = 1'b0;
    end

    // rd_done only fires in RD_*/WAIT_*, where the address selects the target word.
    if (rd_done) begin
      if (avm_address == SYSID_ADDR_TS) read_ts_d = rd_data;
      else                              read_id_d = rd_data;
    end

    if (state_q == ST_CHECK) begin
      id_ok_d    = (read_id_q == EXPECTED_ID);
      ts_ok_d    = (read_ts_q == EXPECTED_TS);
      pass_d     = chk_pass;
      attempts_d = sat_inc2(attempts_q);
      if (!chk_pass && retry_ok) retry_d = retry_q + 2'd1;
    end
  end

  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign pass     = pass_q;
  assign read_id  = read_id_q;
  assign read_ts  = read_ts_q;
  assign attempts = attempts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1456583469;
  localparam logic [31:0] BAD_ID = 32'h0000_0005;

  typedef struct packed {
    logic [31:0] cyc;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic [1:0]  att;
    logic [31:0] rid;
    logic [31:0] rts;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;

  // DUT A: READ_LATENCY=1, modelled slave with stall and bad-ID injection
  logic        avm_address_a, avm_read_a, avm_waitrequest_a;
  logic [31:0] avm_readdata_a;
  logic        busy_a, done_a, id_ok_a, ts_ok_a, pass_a;
  logic [31:0] read_id_a, read_ts_a;
  logic [1:0]  attempts_a;

  // DUT B: READ_LATENCY=0, zero-wait combinational slave
  logic        avm_address_b, avm_read_b;
  logic [31:0] avm_readdata_b;
  logic        busy_b, done_b, id_ok_b, ts_ok_b, pass_b;
  logic [31:0] read_id_b, read_ts_b;
  logic [1:0]  attempts_b;

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(1),
                       .MAX_RETRIES(2), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address_a), .avm_read(avm_read_a),
    .avm_waitrequest(avm_waitrequest_a), .avm_readdata(avm_readdata_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .pass(pass_a),
    .read_id(read_id_a), .read_ts(read_ts_a), .attempts(attempts_a)
  );

  sysid_boot_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
                       .MAX_RETRIES(2), .AUTO_START(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(1'b0),
    .avm_address(avm_address_b), .avm_read(avm_read_b),
    .avm_waitrequest(1'b0), .avm_readdata(avm_readdata_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .pass(pass_b),
    .read_id(read_id_b), .read_ts(read_ts_b), .attempts(attempts_b)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- slave model for DUT A ----------------
  int   stall_cfg = 0;   // stall cycles applied to each ID read
  int   bad_until = 0;   // ID reads numbered below this return BAD_ID
  int   id_reads  = 0;
  int   stall_cnt = 0;
  logic [31:0] slv_rdata_q = 32'hDEAD_BEEF;
  logic acc_addr[$];

  assign avm_waitrequest_a = avm_read_a && !avm_address_a && (stall_cnt < stall_cfg);
  assign avm_readdata_a    = slv_rdata_q;

  // Data is valid only in the single cycle after acceptance.
  always @(posedge clock) begin
    slv_rdata_q <= 32'hDEAD_BEEF;
    if (avm_read_a) begin
      if (avm_waitrequest_a) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        acc_addr.push_back(avm_address_a);
        if (!avm_address_a) begin
          slv_rdata_q <= (id_reads < bad_until) ? BAD_ID : EXP_ID;
          id_reads    <= id_reads + 1;
        end else begin
          slv_rdata_q <= EXP_TS;
        end
      end
    end
  end

  assign avm_readdata_b = avm_address_b ? EXP_TS : EXP_ID;

  // ---------------- scoreboard ----------------
  int   checks    = 0;
  int   failures  = 0;
  exp_t exp_q[$];
  int   start_cyc = 0;
  int   done_cnt  = 0;
  int   b_done_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input int c, input logic p, input logic io, input logic to,
                                  input logic [1:0] a, input logic [31:0] ri);
    exp_t e;
    e.cyc = 32'(c); e.pass = p; e.id_ok = io; e.ts_ok = to; e.att = a;
    e.rid = ri; e.rts = EXP_TS;
    return e;
  endfunction

  // Cycle 1 is the cycle begun by the start-sampling edge.
  task automatic run_monitor();
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (done_a && !prev) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_done: got done with empty queue, required a pending sequence");
        end else begin
          e = exp_q.pop_front();
          check("sb_done_cycle", 32'(cyc - start_cyc + 1), e.cyc);
          check("sb_pass",       32'(pass_a),     32'(e.pass));
          check("sb_id_ok",      32'(id_ok_a),    32'(e.id_ok));
          check("sb_ts_ok",      32'(ts_ok_a),    32'(e.ts_ok));
          check("sb_attempts",   32'(attempts_a), 32'(e.att));
          check("sb_read_id",    read_id_a,       e.rid);
          check("sb_read_ts",    read_ts_a,       e.rts);
          check("sb_busy_low",   32'(busy_a),     32'd0);
          check("sb_no_read",    32'(avm_read_a), 32'd0);
        end
      end
      prev = done_a;
    end
  endtask

  task automatic run_b_monitor();
    forever begin
      @(negedge clock);
      if (done_b && b_done_cyc < 0) b_done_cyc = cyc;
    end
  endtask

  // Waits for done_cnt to reach target; counts cycles spent reading address 0.
  task automatic wait_done(input int target, output int rd_id_cycles);
    int n;
    n = 0;
    rd_id_cycles = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clock);
      n++;
      if (avm_read_a && (avm_address_a == 1'b0)) rd_id_cycles++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d done events, required %0d", done_cnt, target);
    end
  endtask

  // Pulse start from DONE; returns #1 after the sampling edge.
  task automatic do_start(input bit push, input exp_t e);
    @(negedge clock);
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clock);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    check("start_clr_done",     32'(done_a),     32'd0);
    check("start_clr_pass",     32'(pass_a),     32'd0);
    check("start_clr_attempts", 32'(attempts_a), 32'd0);
    check("start_busy",         32'(busy_a),     32'd1);
  endtask

  // Releases reset at a negedge; the next posedge is the sampling edge.
  task automatic release_reset(input exp_t e);
    @(negedge clock);
    exp_q.push_back(e);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, 32'({avm_address_a, avm_read_a, busy_a, done_a,
                                 id_ok_a, ts_ok_a, pass_a, attempts_a}), 32'd0);
    check({tag, "_read_id"}, read_id_a, 32'd0);
    check({tag, "_read_ts"}, read_ts_a, 32'd0);
  endtask

  initial begin
    int rd_cyc;
    int base;
    fork
      run_monitor();
      run_b_monitor();
    join_none

    // 1) Reset state, then AUTO_START pass with no stall
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    check("reset_b_busy", 32'(busy_b), 32'd0);
    base = acc_addr.size();
    release_reset(mk_exp(6, 1'b1, 1'b1, 1'b1, 2'd1, EXP_ID));
    wait_done(1, rd_cyc);
    check("auto_rd_id_cycles", 32'(rd_cyc), 32'd1);
    check("auto_num_reads", 32'(acc_addr.size() - base), 32'd2);
    if (acc_addr.size() - base >= 2) begin
      check("auto_first_addr",  32'(acc_addr[base]),     32'd0);
      check("auto_second_addr", 32'(acc_addr[base + 1]), 32'd1);
    end
    check("lat0_done_cycle", 32'(b_done_cyc - start_cyc + 1), 32'd4);
    check("lat0_pass",       32'(pass_b),  32'd1);
    check("lat0_read_ts",    read_ts_b,    EXP_TS);

    // 2) Three-cycle stall on the ID read: strobe held 4 cycles, done 3 later
    stall_cfg = 3;
    do_start(1'b1, mk_exp(9, 1'b1, 1'b1, 1'b1, 2'd1, EXP_ID));
    wait_done(2, rd_cyc);
    check("stall_rd_id_cycles", 32'(rd_cyc), 32'd4);
    stall_cfg = 0;

    // 3) ID always wrong: three sequences, then DONE with failure
    bad_until = id_reads + 100;
    do_start(1'b1, mk_exp(16, 1'b0, 1'b0, 1'b1, 2'd3, BAD_ID));
    wait_done(3, rd_cyc);
    check("retry_rd_id_cycles", 32'(rd_cyc), 32'd3);

    // 4) ID wrong on first attempt only
    bad_until = id_reads + 1;
    do_start(1'b1, mk_exp(11, 1'b1, 1'b1, 1'b1, 2'd2, EXP_ID));
    wait_done(4, rd_cyc);
    bad_until = 0;

    // 5) start while busy is ignored and not queued
    do_start(1'b1, mk_exp(6, 1'b1, 1'b1, 1'b1, 2'd1, EXP_ID));
    @(negedge clock);
    check("busy_before_pulse", 32'(busy_a), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(5, rd_cyc);
    repeat (10) @(negedge clock);
    check("no_queued_rerun", 32'(done_cnt), 32'd5);
    check("done_held",       32'(done_a),   32'd1);

    // 6) Asynchronous reset in WAIT_TS, then a fresh automatic sequence
    do_start(1'b0, mk_exp(0, 1'b0, 1'b0, 1'b0, 2'd0, EXP_ID));
    repeat (3) @(posedge clock);
    #2;
    check("wait_ts_state", 32'({busy_a, avm_read_a, avm_address_a}), 32'b101);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clock);
    release_reset(mk_exp(6, 1'b1, 1'b1, 1'b1, 2'd1, EXP_ID));
    wait_done(6, rd_cyc);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences the system-ID slave: reads word 0 (system ID), then word 1 (build timestamp), and compares both against expected values.
- Runs automatically after reset and again on request, retrying on mismatch.
- Exposes pass/fail status and the captured words to the CPU-side glue logic and a board LED.
- Sits between the system-ID slave and the boot/status logic of the NIOS II system.

Parameters:
- EXPECTED_ID, 32'h00000000, value the system ID (address 0) must return
- EXPECTED_TS, 32'd1456583469, value the timestamp (address 1) must return
- READ_LATENCY, 1, fixed cycles from read acceptance to valid readdata (0..3)
- MAX_RETRIES, 2, extra full read sequences attempted after a mismatch (0..3)
- AUTO_START, 1, 1 = start one sequence automatically on leaving reset

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a new check sequence; sampled only in IDLE/DONE
- avm_address  out  1  slave word address: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- avm_readdata  in  32  slave read data
- busy  out  1  sequence in progress
- done  out  1  level; sequence finished, held until next start
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- pass  out  1  id_ok AND ts_ok, registered in CHECK
- read_id  out  32  last captured ID word
- read_ts  out  32  last captured timestamp word
- attempts  out  2  sequences run in current check, saturating at 3

Behaviour:
- Reset (asynchronous, reset_n low): every output is 0, state is IDLE, retry counter is 0. A pending start is lost.
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE.
- IDLE: on the first clock after reset release, AUTO_START=1 enters RD_ID. Otherwise IDLE waits for start=1.
- DONE: start=1 clears done/pass/id_ok/ts_ok, resets attempts to 0 and enters RD_ID.
- start during busy is ignored and not queued.
- RD_ID:
  - avm_read=1, avm_address=0; both held stable while avm_waitrequest=1.
  - Acceptance happens on the cycle avm_waitrequest=0. On acceptance, avm_read drops next cycle.
  - If READ_LATENCY=0, avm_readdata is captured into read_id on the acceptance cycle and the FSM goes to RD_TS.
  - Otherwise the FSM goes to WAIT_ID.
- WAIT_ID: lasts READ_LATENCY cycles. A down-counter is loaded with READ_LATENCY-1. avm_readdata is captured in the last cycle, then the FSM goes to RD_TS.
- RD_TS/WAIT_TS: identical to RD_ID/WAIT_ID with avm_address=1, capturing into read_ts; then CHECK.
- CHECK (1 cycle):
  - Registers id_ok, ts_ok and pass; increments attempts (saturating at 3).
  - If pass=0 and the retry counter < MAX_RETRIES: increment the retry counter and re-enter RD_ID.
  - Otherwise enter DONE.
- DONE: done=1, busy=0. status, read_id and read_ts hold.
- busy=1 in every state except IDLE and DONE.
- Timing: with READ_LATENCY=1 and waitrequest=0, done rises 6 clocks after the start-sampling edge, and each retry adds 5 clocks.
- Single outstanding read only; no pipelining.
- avm_read is never asserted in IDLE, CHECK or DONE.
- No timeout: an indefinitely stalled slave keeps the FSM in RD_*, and reset_n is the only escape.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams)
  - address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1
- One natural sub-module, sysid_read_port: single-read Avalon handshake plus latency counter, with a go/done/data interface. It is instantiated once, and the FSM drives its address.

Test Plan:
- Reset release, AUTO_START=1, slave returns 0 / 1456583469, L=1, no stall -> reads at address 0 then 1; done=1 at cycle 6; pass=1, attempts=1.
- avm_waitrequest high 3 cycles on the ID read -> avm_read and avm_address=0 held stable for 4 cycles; done delayed by exactly 3; pass=1.
- Slave returns ID 0x00000005 on every read, MAX_RETRIES=2 -> three sequences run, done=1, id_ok=0, ts_ok=1, pass=0, attempts=3, read_id=0x5.
- Mismatch on first attempt only, then correct -> second sequence passes; pass=1, attempts=2, done at cycle 11.
- reset_n asserted low during WAIT_TS -> all outputs 0 immediately (asynchronous); on release with AUTO_START=1 a fresh sequence completes with pass=1.
- start pulsed while busy=1 is ignored; start pulsed in DONE clears status and reruns; READ_LATENCY=0 variant reaches done at cycle 4.
